// File: rtl/i2c_target_phy.sv
// i2c_target_phy
// I2C target (slave) byte engine. Synchronizes and run-length filters the
// open-drain bus lines, detects START/STOP, matches a 7-bit address, ACKs every
// written byte and shifts bytes in/out for user logic via 1-cycle strobes.
//
// Parameters
//   ADDR        7-bit target address (default 7'h50)
//   FILTER_LEN  identical synchronized samples needed to move a filtered line (1..7)
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   i2c_sda, i2c_scl  open-drain bus lines (only ever driven low or released)
//   start_det         1-cycle pulse on START / repeated START
//   stop_det          1-cycle pulse on STOP
//   selected          high from address ACK until the next START/STOP
//   rw                R/W bit of the last matched address byte (1 = master reads)
//   rx_data/rx_valid  last byte written by the master, strobed when updated
//   tx_data/tx_valid  next byte returned to the master (tx_valid used only when stretching)
//   tx_req            1-cycle pulse on the cycle tx_data is loaded
//   master_ack        ACK bit the master gave for the last transmitted byte (1 = ACK)
//
// Build option
//   I2C_TARGET_STRETCH_EN  when defined, a load point with tx_valid=0 holds SCL
//                          low (STRETCH state) until tx_valid rises. Otherwise
//                          SCL is never driven and tx_data is taken unconditionally.

module i2c_target_phy #(
  parameter logic [6:0] ADDR       = 7'h50,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        i2c_sda,
  inout  wire        i2c_scl,
  output logic       start_det,
  output logic       stop_det,
  output logic       selected,
  output logic       rw,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_req,
  output logic       master_ack
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_ADDR     = 4'd1;
  localparam logic [3:0] S_ADDR_ACK = 4'd2;
  localparam logic [3:0] S_RX       = 4'd3;
  localparam logic [3:0] S_RX_ACK   = 4'd4;
  localparam logic [3:0] S_TX       = 4'd5;
  localparam logic [3:0] S_TX_ACK   = 4'd6;
  localparam logic [3:0] S_IGNORE   = 4'd7;
`ifdef I2C_TARGET_STRETCH_EN
  localparam logic [3:0] S_STRETCH  = 4'd8;
`endif

  localparam logic [2:0] FLT_MAX = 3'(FILTER_LEN - 1);

  // Input path: synchronizer, run filter, one-cycle-delayed copy for edges.
  logic [1:0] sda_sync, scl_sync;
  logic [2:0] sda_cnt, scl_cnt;
  logic       sda_f, scl_f, sda_d, scl_d;

  // NOTE: non-blocking assignments for all state, so every flop in a block
  // samples the values from before the clock edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sda_sync <= 2'b11;
      scl_sync <= 2'b11;
      sda_cnt  <= 3'd0;
      scl_cnt  <= 3'd0;
      sda_f    <= 1'b1;
      scl_f    <= 1'b1;
      sda_d    <= 1'b1;
      scl_d    <= 1'b1;
    end else begin
      sda_sync <= {sda_sync[0], i2c_sda};
      scl_sync <= {scl_sync[0], i2c_scl};

      // A line moves only after FILTER_LEN consecutive samples disagree with it.
      if (sda_sync[1] == sda_f) begin
        sda_cnt <= 3'd0;
      end else if (sda_cnt == FLT_MAX) begin
        sda_f   <= sda_sync[1];
        sda_cnt <= 3'd0;
      end else begin
        sda_cnt <= sda_cnt + 3'd1;
      end

      if (scl_sync[1] == scl_f) begin
        scl_cnt <= 3'd0;
      end else if (scl_cnt == FLT_MAX) begin
        scl_f   <= scl_sync[1];
        scl_cnt <= 3'd0;
      end else begin
        scl_cnt <= scl_cnt + 3'd1;
      end

      sda_d <= sda_f;
      scl_d <= scl_f;
    end
  end

  logic scl_rise, scl_fall, start_cond, stop_cond;
  assign scl_rise   = scl_f & ~scl_d;
  assign scl_fall   = ~scl_f & scl_d;
  // SCL must be stable high across the SDA edge to count as START/STOP.
  assign start_cond = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_cond  = scl_f & scl_d & ~sda_d & sda_f;

  logic [3:0] state;
  logic [3:0] bit_cnt;
  logic [7:0] shift;
  logic [7:0] tx_shift;
  logic       sda_low;
  logic       scl_low;
  logic       load_pt;
  logic       tx_go;

  // Load point: the SCL fall that ends an address ACK (read) or a master ACK.
  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    load_pt = 1'b0;
    if (!start_cond && !stop_cond && scl_fall)
      load_pt = ((state == S_ADDR_ACK) && rw) || ((state == S_TX_ACK) && master_ack);
  end

`ifdef I2C_TARGET_STRETCH_EN
  assign tx_go   = (load_pt || (state == S_STRETCH)) && tx_valid;
  assign i2c_scl = scl_low ? 1'b0 : 1'bz;
`else
  logic unused_tx_valid;
  assign unused_tx_valid = tx_valid;
  assign tx_go   = load_pt;
  assign i2c_scl = 1'bz;
`endif

  assign i2c_sda = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      bit_cnt    <= 4'd0;
      shift      <= 8'h00;
      tx_shift   <= 8'h00;
      sda_low    <= 1'b0;
      scl_low    <= 1'b0;
      selected   <= 1'b0;
      rw         <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      tx_req     <= 1'b0;
      start_det  <= 1'b0;
      stop_det   <= 1'b0;
      master_ack <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;

      if (start_cond) begin
        state     <= S_ADDR;
        bit_cnt   <= 4'd0;
        sda_low   <= 1'b0;
        selected  <= 1'b0;
        start_det <= 1'b1;
      end else if (stop_cond) begin
        state    <= S_IDLE;
        sda_low  <= 1'b0;
        selected <= 1'b0;
        stop_det <= 1'b1;
      end else begin
        case (state)
          S_ADDR: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda_f};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              if (shift[7:1] == ADDR) begin
                state   <= S_ADDR_ACK;
                sda_low <= 1'b1;
                rw      <= shift[0];
              end else begin
                state <= S_IGNORE;
              end
            end
          end
          S_ADDR_ACK: begin
            // The read path is completed by the shared load logic below.
            if (scl_fall) begin
              selected <= 1'b1;
              if (!rw) begin
                sda_low <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= S_RX;
              end
            end
          end
          S_RX: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda_f};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
              sda_low  <= 1'b1;
              state    <= S_RX_ACK;
            end
          end
          S_RX_ACK: begin
            if (scl_fall) begin
              sda_low <= 1'b0;
              bit_cnt <= 4'd0;
              state   <= S_RX;
            end
          end
          S_TX: begin
            // bit_cnt counts SCL falls since bit 7 went out.
            if (scl_fall) begin
              if (bit_cnt == 4'd7) begin
                sda_low <= 1'b0;
                state   <= S_TX_ACK;
              end else begin
                sda_low  <= ~tx_shift[6];
                tx_shift <= {tx_shift[6:0], 1'b0};
                bit_cnt  <= bit_cnt + 4'd1;
              end
            end
          end
          S_TX_ACK: begin
            if (scl_rise)
              master_ack <= ~sda_f;
            else if (scl_fall && !master_ack)
              state <= S_IGNORE;
          end
`ifdef I2C_TARGET_STRETCH_EN
          S_STRETCH: ;
`endif
          S_IDLE, S_IGNORE: ;
          default: state <= S_IDLE;
        endcase

        if (tx_go) begin
          tx_shift <= tx_data;
          tx_req   <= 1'b1;
          sda_low  <= ~tx_data[7];
          bit_cnt  <= 4'd0;
          state    <= S_TX;
        end
`ifdef I2C_TARGET_STRETCH_EN
        else if (load_pt) begin
          state   <= S_STRETCH;
          scl_low <= 1'b1;
        end
        // SCL is let go one cycle after the stretched load, so bit 7 is set up first.
        if (scl_low && state != S_STRETCH)
          scl_low <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_phy.sv
// Testbench for i2c_target_phy: a behavioural I2C master drives the bus,
// a reference model derives expected strobe events and bus responses, and a
// monitor process compares DUT strobes against the expected-event queue.

module tb_i2c_target_phy;

  localparam logic [6:0] ADDR = 7'h50;
  localparam int Q = 10;  // quarter SCL period in clk cycles

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_sda_low = 1'b0;
  logic m_scl_low = 1'b0;
  wire  sda_bus, scl_bus;

  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  assign scl_bus = m_scl_low ? 1'b0 : 1'bz;
  pullup (sda_bus);
  pullup (scl_bus);

  logic       start_det, stop_det, selected, rw, rx_valid, tx_req, master_ack;
  logic [7:0] rx_data;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b1;

  i2c_target_phy #(.ADDR(ADDR), .FILTER_LEN(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .i2c_sda    (sda_bus),
    .i2c_scl    (scl_bus),
    .start_det  (start_det),
    .stop_det   (stop_det),
    .selected   (selected),
    .rw         (rw),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_req     (tx_req),
    .master_ack (master_ack)
  );

  always #10 clk = ~clk;

  typedef enum int {EV_START = 0, EV_STOP = 1, EV_RX = 2, EV_TXREQ = 3} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected: got event kind %0d data %02h, expected none", int'(k), d);
    end else begin
      e = exp_q.pop_front();
      check("sb_kind", int'(k), int'(e.kind));
      if (k == EV_RX || k == EV_TXREQ)
        check("sb_data", 32'(d), 32'(e.data));
    end
  endtask

  // Monitor: every DUT strobe is matched against the next expected event.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (start_det) observe(EV_START, 8'h00);
        if (stop_det)  observe(EV_STOP, 8'h00);
        if (rx_valid)  observe(EV_RX, rx_data);
        if (tx_req)    observe(EV_TXREQ, tx_data);
      end
    end
  end

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  // ---------------- bus master ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_scl_high(input int budget);
    int n;
    n = 0;
    while (scl_bus !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (scl_bus !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL scl_release_timeout: SCL still low after %0d cycles, expected high", budget);
    end
  endtask

  // Drives (b=0) or releases (b=1) SDA for one SCL clock and samples the bus mid-high.
  task automatic bit_xfer(input bit b, output bit seen);
    m_sda_low = ~b;
    wait_cyc(Q);
    m_scl_low = 1'b0;
    wait_scl_high(1000);
    wait_cyc(Q);
    seen = sda_bus;
    wait_cyc(Q);
    m_scl_low = 1'b1;
    wait_cyc(Q);
  endtask

  task automatic send_start();
    m_sda_low = 1'b0;
    wait_cyc(Q);
    m_scl_low = 1'b0;
    wait_scl_high(1000);
    wait_cyc(Q);
    m_sda_low = 1'b1;
    wait_cyc(Q);
    m_scl_low = 1'b1;
    wait_cyc(Q);
  endtask

  task automatic send_stop();
    m_sda_low = 1'b1;
    wait_cyc(Q);
    m_scl_low = 1'b0;
    wait_scl_high(1000);
    wait_cyc(Q);
    m_sda_low = 1'b0;
    wait_cyc(2 * Q);
  endtask

  // Returns the 9th-clock SDA level: 0 = target ACK.
  task automatic byte_write(input logic [7:0] b, output bit ack);
    bit s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
    bit_xfer(1'b1, ack);
  endtask

  // ---------------- transactions with reference model ----------------
  task automatic do_write(input logic [7:0] addr_byte, input int n, input logic [7:0] data[4]);
    bit match;
    bit ack;
    match = (addr_byte[7:1] == ADDR);
    expect_ev(EV_START, 8'h00);
    if (match)
      for (int k = 0; k < n; k++) expect_ev(EV_RX, data[k]);
    expect_ev(EV_STOP, 8'h00);

    send_start();
    byte_write(addr_byte, ack);
    check("wr_addr_ack", 32'(ack), match ? 32'd0 : 32'd1);
    check("wr_selected", 32'(selected), 32'(match));
    if (match) check("wr_rw", 32'(rw), 32'd0);
    for (int k = 0; k < n; k++) begin
      byte_write(data[k], ack);
      check("wr_data_ack", 32'(ack), match ? 32'd0 : 32'd1);
    end
    send_stop();
    check("wr_selected_after_stop", 32'(selected), 32'd0);
  endtask

  // Reads n bytes, ACKing all but the last, which is NACKed.
  task automatic do_read(input int n, input logic [7:0] data[4]);
    bit         ack, s;
    logic [7:0] b;
    expect_ev(EV_START, 8'h00);
    for (int k = 0; k < n; k++) expect_ev(EV_TXREQ, data[k]);
    expect_ev(EV_STOP, 8'h00);

    tx_data = data[0];
    send_start();
    byte_write({ADDR, 1'b1}, ack);
    check("rd_addr_ack", 32'(ack), 32'd0);
    check("rd_selected", 32'(selected), 32'd1);
    check("rd_rw", 32'(rw), 32'd1);
    for (int k = 0; k < n; k++) begin
      for (int i = 7; i >= 0; i--) begin
        bit_xfer(1'b1, s);
        b[i] = s;
      end
      check("rd_byte", 32'(b), 32'(data[k]));
      if (k < n - 1) tx_data = data[k + 1];
      bit_xfer(k == n - 1, s);
      check("rd_master_ack", 32'(master_ack), (k == n - 1) ? 32'd0 : 32'd1);
    end
    check("rd_sda_released_after_nack", 32'(sda_bus), 32'd1);
    send_stop();
    check("rd_selected_after_stop", 32'(selected), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] d[4];
    logic [7:0] a;
    logic [7:0] b;
    bit         s, ack;
    int         kind, n, lows;

    // Reset values
    wait_cyc(5);
    check("rst_selected", 32'(selected), 32'd0);
    check("rst_rw", 32'(rw), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_strobes", 32'({rx_valid, tx_req, start_det, stop_det}), 32'd0);
    check("rst_master_ack", 32'(master_ack), 32'd0);
    check("rst_sda_released", 32'(sda_bus), 32'd1);
    check("rst_scl_released", 32'(scl_bus), 32'd1);
    rst = 1'b0;
    wait_cyc(2 * Q);

    // Write 0x3C to address 0x50
    d = '{8'h3C, 8'h00, 8'h00, 8'h00};
    do_write(8'hA0, 1, d);

    // Non-matching address 0x51: no ACKs, no rx_valid
    d = '{8'h55, 8'h00, 8'h00, 8'h00};
    do_write(8'hA2, 1, d);

    // Read 0x5A (ACK) then 0xC3 (NACK)
    d = '{8'h5A, 8'hC3, 8'h00, 8'h00};
    do_read(2, d);

    // Repeated START after 4 data bits aborts the byte; next address is accepted
    expect_ev(EV_START, 8'h00);
    expect_ev(EV_START, 8'h00);
    expect_ev(EV_TXREQ, 8'h96);
    expect_ev(EV_STOP, 8'h00);
    tx_data = 8'h96;
    send_start();
    byte_write(8'hA0, ack);
    check("rs_first_addr_ack", 32'(ack), 32'd0);
    bit_xfer(1'b1, s);
    bit_xfer(1'b0, s);
    bit_xfer(1'b1, s);
    bit_xfer(1'b1, s);
    send_start();
    check("rs_selected_cleared", 32'(selected), 32'd0);
    byte_write({ADDR, 1'b1}, ack);
    check("rs_second_addr_ack", 32'(ack), 32'd0);
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      b[i] = s;
    end
    check("rs_rd_byte", 32'(b), 32'h96);
    bit_xfer(1'b1, s);
    send_stop();

`ifdef I2C_TARGET_STRETCH_EN
    // Stretch: tx_valid low for 200 cycles holds SCL low, then bit 7 appears
    expect_ev(EV_START, 8'h00);
    expect_ev(EV_TXREQ, 8'hB7);
    expect_ev(EV_STOP, 8'h00);
    tx_valid = 1'b0;
    tx_data  = 8'hB7;
    send_start();
    byte_write({ADDR, 1'b1}, ack);
    check("st_addr_ack", 32'(ack), 32'd0);
    m_sda_low = 1'b0;
    m_scl_low = 1'b0;
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (scl_bus === 1'b0) lows++;
    end
    check("st_scl_held_cycles", 32'(lows), 32'd200);
    tx_valid = 1'b1;
    wait_scl_high(20);
    wait_cyc(Q);
    b[7] = sda_bus;
    wait_cyc(Q);
    m_scl_low = 1'b1;
    wait_cyc(Q);
    for (int i = 6; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      b[i] = s;
    end
    check("st_rd_byte", 32'(b), 32'hB7);
    bit_xfer(1'b1, s);
    send_stop();
`endif

    // Reset while the target drives the address ACK
    expect_ev(EV_START, 8'h00);
    send_start();
    for (int i = 7; i >= 0; i--) begin
      a = {ADDR, 1'b1};
      bit_xfer(a[i], s);
    end
    check("rst_mid_ack_driven", 32'(sda_bus), 32'd0);
    check("rst_mid_rw_latched", 32'(rw), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_sda_released", 32'(sda_bus), 32'd1);
    check("rst_mid_outputs", 32'({selected, rw, rx_valid, tx_req, start_det, stop_det, master_ack}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(Q);
    // Without a new START the next byte must be ignored
    byte_write(8'hA0, ack);
    check("rst_no_start_no_ack", 32'(ack), 32'd1);
    expect_ev(EV_STOP, 8'h00);
    send_stop();
    check("rst_selected_idle", 32'(selected), 32'd0);

    // Randomized transactions
    for (int t = 0; t < 10; t++) begin
      kind = int'($urandom_range(0, 2));
      n    = int'($urandom_range(1, 3));
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      if (kind == 0) begin
        do_read(n, d);
      end else if (kind == 1) begin
        do_write({ADDR, 1'b0}, n, d);
      end else begin
        a = 8'($urandom);
        a[0] = 1'b0;
        if (a[7:1] == ADDR) a[7:1] = ADDR + 7'd1;
        do_write(a, n, d);
      end
    end

    wait_cyc(50);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_target_phy.md
# i2c_target_phy

I2C target-side (slave) byte engine, the far end of the bus from the I2C master phy. It sits behind the programmer's open-drain `i2c_sda`/`i2c_scl` pins so that the board can emulate an I2C memory device. The block filters and edge-detects the bus and detects START/STOP. It matches a 7-bit address, ACKs writes, and exchanges bytes with user logic over a strobe handshake.

## Interface
- `ADDR`, default 7'h50: target address matched against the first 7 bits after START.
- `FILTER_LEN`, default 3: consecutive identical synchronized samples required before a filtered line changes (1–7).
- `clk` in 1: system clock (50 MHz in this design).
- `rst` in 1: reset, synchronous, active-high.
- `i2c_sda` inout 1: open-drain; driven 0 or released ('z').
- `i2c_scl` inout 1: open-drain; released unless stretching (see Configuration).
- `start_det` out 1: 1-cycle pulse on START or repeated START.
- `stop_det` out 1: 1-cycle pulse on STOP.
- `selected` out 1: high from address ACK until STOP/START.
- `rw` out 1: R/W bit of the last matched address byte (1 = master reads).
- `rx_data` out 8: last byte written by the master, MSB first on the wire.
- `rx_valid` out 1: 1-cycle pulse when `rx_data` updates.
- `tx_data` in 8: next byte to return to the master.
- `tx_valid` in 1: `tx_data` ready; used only with stretching.
- `tx_req` out 1: 1-cycle pulse on the cycle `tx_data` is loaded.
- `master_ack` out 1: ACK bit from the last transmitted byte (1 = ACK).

## Operation
- Input path: 2-flop synchronizer per line, then a FILTER_LEN majority-free run filter. This gives filtered `scl_f`/`sda_f` and 1-cycle `scl_rise`/`scl_fall` strobes.
- START: `sda_f` falls while `scl_f`=1. STOP: `sda_f` rises while `scl_f`=1. Both are honoured in every state.
  - START goes to ADDR with the bit counter cleared.
  - STOP goes to IDLE.
  - Both release SDA.
- States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE (plus STRETCH with the macro).
- ADDR: shift `sda_f` on each `scl_rise`, 8 bits.
  - On the 8th `scl_fall`, if bits[7:1]==ADDR: go to ADDR_ACK, drive SDA low, latch `rw`.
  - Otherwise go to IGNORE.
- ADDR_ACK: on the next `scl_fall`, set `selected`=1.
  - If `rw`=0: release SDA and go to RX.
  - If `rw`=1: load `tx_data`, pulse `tx_req`, drive bit 7, and go to TX.
- RX: 8 samples on `scl_rise`. On the 8th `scl_fall`, `rx_data` updates, `rx_valid` pulses, SDA is driven low, and the state goes to RX_ACK. Every byte is ACKed.
- RX_ACK: release SDA on the next `scl_fall`, then RX.
- TX: SDA value is updated one cycle after each `scl_fall` (bits 6..0). After bit 0 the following `scl_fall` releases SDA and the state goes to TX_ACK.
- TX_ACK: sample SDA on `scl_rise` into `master_ack`.
  - On `scl_fall`: if ACK, load the next byte (`tx_req` pulse) and go to TX.
  - If NACK, go to IGNORE.
- IGNORE: SDA released; leave only on START/STOP.
- SDA is never changed while `scl_f`=1, except by START/STOP detection, which releases it.

## Timing
- Pin-to-strobe latency: 2 (sync) + FILTER_LEN cycles, equal for both lines so ordering is preserved.
- SDA drive updates 1 cycle after `scl_fall`. With the 1 MHz master (≥25 cycles SCL low), setup is met.
- `rx_valid`, `tx_req`, `start_det`, `stop_det` are exactly one cycle wide.
- Reset values: SDA/SCL released; `selected`, `rw`, `rx_valid`, `tx_req`, `start_det`, `stop_det`, `master_ack` = 0; `rx_data` = 8'h00; state IDLE; filters preset to 1 (bus idle).
- Reset mid-transfer releases both lines on the next cycle with no STOP required. The bus is then treated as idle, and a later START is needed before anything is accepted.
- START arriving mid-byte aborts the byte: no `rx_valid` and no `tx_req`.

## Configuration
- `I2C_TARGET_STRETCH_EN` defined: at any load point (ADDR_ACK→TX, TX_ACK→TX), if `tx_valid`=0 the block enters STRETCH and holds SCL low.
  - Once `tx_valid`=1 it loads, pulses `tx_req`, drives bit 7, and releases SCL one cycle later.
  - STOP/START cannot occur while SCL is held.
  - `rst` releases SCL.
- Undefined: `tx_valid` is ignored, SCL is never driven, and `tx_data` is sampled unconditionally at the load point.

## Test plan
- Write 0xA0 (addr 0x50, W), then 0x3C, then STOP. Required: ACK low on both 9th clocks, `rx_data`=0x3C with one `rx_valid`, then `stop_det`, and `selected` back to 0.
- Address 0xA2 (addr 0x51): SDA stays released for all 9 clocks, no `rx_valid`, IGNORE until STOP.
- Read 0xA1 with `tx_data`=0x5A, then 0xC3, master ACK then NACK. Required: bus bits 0x5A then 0xC3, two `tx_req` pulses, final `master_ack`=0, SDA released after the NACK.
- Repeated START after 4 data bits: no `rx_valid`, a `start_det` pulse, and the following address byte is accepted.
- STRETCH_EN: read with `tx_valid` held 0 for 200 cycles. Required: SCL low for 200 cycles, then bit 7 of `tx_data`, and one `tx_req`.
- `rst` asserted while SDA is driven low for an ACK: SDA is 'z' on the next cycle and all outputs are at their reset values.
